// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access on a word-only data memory.
// Sub-word stores use read-modify-write; misaligned accesses are rejected.
module load_store_unit #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Sign,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Done,
  output logic        Misalign,
  output logic        Busy,
  output logic [31:0] MemAddr,
  output logic [31:0] MemDin,
  output logic        MemWe,
  input  logic [31:0] MemDout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MERGE,
    WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;

  logic        size_rsv;
  logic        mis_raw;
  logic        reject;
  logic [31:0] addr_al;
  logic [4:0]  shift;
  logic [31:0] lane;
  logic [31:0] ld_val;
  logic [31:0] mask;
  logic [31:0] mrg_val;

  assign size_rsv = (Size == 2'b11);
  assign mis_raw  = ((Size == 2'b01) & Addr[0]) |
                    ((Size == 2'b10) & (|Addr[1:0]));
  assign reject   = size_rsv | (MISALIGN_EN & mis_raw);

  always_comb begin
    addr_al = Addr;
    if (Size == 2'b01) addr_al[0] = 1'b0;
    if (Size == 2'b10) addr_al[1:0] = 2'b00;
  end

  // Lane shift is derived from the latched byte address.
  assign shift = {addr_q[1:0], 3'b000};
  assign lane  = MemDout >> shift;

  always_comb begin
    ld_val = MemDout;
    unique case (size_q)
      2'b00:   ld_val = {{24{sign_q & lane[7]}}, lane[7:0]};
      2'b01:   ld_val = {{16{sign_q & lane[15]}}, lane[15:0]};
      default: ld_val = MemDout;
    endcase
  end

  assign mask    = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff)
                   << shift;
  assign mrg_val = (MemDout & ~mask) | ((wdata_q << shift) & mask);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          if (reject) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            addr_d  = addr_al;
            wdata_d = WData;
            size_d  = Size;
            sign_d  = Sign;
            if (!Wr) begin
              state_d = LOAD;
            end else if (Size == 2'b10) begin
              merge_d = WData;
              state_d = WRITE;
            end else begin
              state_d = MERGE;
            end
          end
        end
      end
      LOAD: begin
        rdata_d = ld_val;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      MERGE: begin
        merge_d = mrg_val;
        state_d = WRITE;
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign RData    = rdata_q;
  assign Done     = done_q;
  assign Misalign = mis_q;
  assign Busy     = (state_q != IDLE);
  assign MemAddr  = {addr_q[31:2], 2'b00};
  assign MemDin   = merge_q;
  // Gating with Rst keeps a reset edge from committing an aborted store.
  assign MemWe    = (state_q == WRITE) & ~Rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table over two instances
// (MISALIGN_EN=1 and 0) plus back-to-back and reset-abort sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic        wr;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr, wdata;
  logic        sel;

  logic [31:0] rdata0, rdata1, maddr0, maddr1, din0, din1, dout0, dout1;
  logic        done0, done1, mis0, mis1, busy0, busy1, we0, we1;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MISALIGN_EN(1'b1)) u0 (
    .Clk(clk), .Rst(rst), .Req(req0), .Wr(wr), .Size(size),
    .Sign(sign), .Addr(addr), .WData(wdata), .RData(rdata0),
    .Done(done0), .Misalign(mis0), .Busy(busy0), .MemAddr(maddr0),
    .MemDin(din0), .MemWe(we0), .MemDout(dout0)
  );

  load_store_unit #(.MISALIGN_EN(1'b0)) u1 (
    .Clk(clk), .Rst(rst), .Req(req1), .Wr(wr), .Size(size),
    .Sign(sign), .Addr(addr), .WData(wdata), .RData(rdata1),
    .Done(done1), .Misalign(mis1), .Busy(busy1), .MemAddr(maddr1),
    .MemDin(din1), .MemWe(we1), .MemDout(dout1)
  );

  assign dout0 = mem0[maddr0[6:2]];
  assign dout1 = mem1[maddr1[6:2]];

  always @(posedge clk) begin
    if (we0) mem0[maddr0[6:2]] <= din0;
    if (we1) mem1[maddr1[6:2]] <= din1;
  end

  wire [31:0] s_rdata = sel ? rdata1 : rdata0;
  wire        s_done  = sel ? done1 : done0;
  wire        s_mis   = sel ? mis1 : mis0;
  wire        s_busy  = sel ? busy1 : busy0;
  wire        s_we    = sel ? we1 : we0;
  wire [31:0] s_maddr = sel ? maddr1 : maddr0;
  wire [31:0] s_din   = sel ? din1 : din0;

  typedef struct {
    bit          sel;
    bit          wr;
    bit [1:0]    size;
    bit          sign;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    int          lat;
    bit          mis;
    int          we;
    bit [31:0]   rd;
    int          widx;
    bit [31:0]   word;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input bit s, input int i);
    return s ? mem1[i] : mem0[i];
  endfunction

  task automatic run(input int k, input vec_t v);
    int lat;
    int wec;
    bit seen;
    logic misv;
    logic [31:0] rdv;
    @(negedge clk);
    sel = v.sel;
    if (v.sel) req1 = 1'b1;
    else req0 = 1'b1;
    wr = v.wr; size = v.size; sign = v.sign;
    addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    lat = 0; wec = 0; seen = 0; misv = 1'bx; rdv = 'x;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (s_we) wec++;
      if (s_done) begin
        seen = 1; lat = c; misv = s_mis; rdv = s_rdata;
      end
    end
    chk($sformatf("v%0d latency", k), lat, v.lat);
    chk($sformatf("v%0d misalign", k), {31'd0, misv}, {31'd0, v.mis});
    chk($sformatf("v%0d memwe_cycles", k), wec, v.we);
    chk($sformatf("v%0d rdata", k), rdv, v.rd);
    chk($sformatf("v%0d mem[%0d]", k, v.widx), memrd(v.sel, v.widx), v.word);
  endtask

  initial begin
    //         sel wr size  sg addr   wdata         lat mis we rd            idx word
    vt[0]  = '{0, 1, 2'b10, 0, 32'h08, 32'h11223344, 2, 0, 1, 32'h00000000, 2, 32'h11223344};
    vt[1]  = '{0, 0, 2'b00, 1, 32'h09, 32'h0,        2, 0, 0, 32'h00000033, 2, 32'h11223344};
    vt[2]  = '{0, 1, 2'b00, 0, 32'h0A, 32'hFFFFFFAB, 3, 0, 1, 32'h00000033, 2, 32'h11AB3344};
    vt[3]  = '{0, 0, 2'b00, 1, 32'h0A, 32'h0,        2, 0, 0, 32'hFFFFFFAB, 2, 32'h11AB3344};
    vt[4]  = '{0, 0, 2'b00, 0, 32'h0A, 32'h0,        2, 0, 0, 32'h000000AB, 2, 32'h11AB3344};
    vt[5]  = '{0, 1, 2'b01, 0, 32'h0A, 32'h1234BEEF, 3, 0, 1, 32'h000000AB, 2, 32'hBEEF3344};
    vt[6]  = '{0, 0, 2'b01, 1, 32'h0A, 32'h0,        2, 0, 0, 32'hFFFFBEEF, 2, 32'hBEEF3344};
    vt[7]  = '{0, 0, 2'b01, 0, 32'h08, 32'h0,        2, 0, 0, 32'h00003344, 2, 32'hBEEF3344};
    vt[8]  = '{0, 0, 2'b01, 1, 32'h03, 32'h0,        1, 1, 0, 32'h00003344, 0, 32'h00000000};
    vt[9]  = '{0, 1, 2'b10, 0, 32'h06, 32'hDEADBEEF, 1, 1, 0, 32'h00003344, 1, 32'h00000000};
    vt[10] = '{0, 0, 2'b11, 0, 32'h00, 32'h0,        1, 1, 0, 32'h00003344, 0, 32'h00000000};
    vt[11] = '{0, 1, 2'b00, 0, 32'h08, 32'h00000080, 3, 0, 1, 32'h00003344, 2, 32'hBEEF3380};
    vt[12] = '{0, 0, 2'b00, 1, 32'h08, 32'h0,        2, 0, 0, 32'hFFFFFF80, 2, 32'hBEEF3380};
    vt[13] = '{0, 0, 2'b10, 0, 32'h08, 32'h0,        2, 0, 0, 32'hBEEF3380, 2, 32'hBEEF3380};
    vt[14] = '{0, 0, 2'b00, 1, 32'h0B, 32'h0,        2, 0, 0, 32'hFFFFFFBE, 2, 32'hBEEF3380};
    vt[15] = '{1, 1, 2'b10, 0, 32'h06, 32'h5A5A5A5A, 2, 0, 1, 32'h00000000, 1, 32'h5A5A5A5A};
    vt[16] = '{1, 0, 2'b01, 0, 32'h07, 32'h0,        2, 0, 0, 32'h00005A5A, 1, 32'h5A5A5A5A};
    vt[17] = '{1, 0, 2'b11, 0, 32'h04, 32'h0,        1, 1, 0, 32'h00005A5A, 1, 32'h5A5A5A5A};
    vt[18] = '{1, 0, 2'b10, 0, 32'h05, 32'h0,        2, 0, 0, 32'h5A5A5A5A, 1, 32'h5A5A5A5A};

    for (int i = 0; i < 32; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    sel = 0; rst = 1; req0 = 0; req1 = 0;
    wr = 0; size = 0; sign = 0; addr = 0; wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rdata", s_rdata, 32'h0);
    chk("rst done", {31'd0, s_done}, 32'h0);
    chk("rst misalign", {31'd0, s_mis}, 32'h0);
    chk("rst busy", {31'd0, s_busy}, 32'h0);
    chk("rst memwe", {31'd0, s_we}, 32'h0);
    chk("rst memaddr", s_maddr, 32'h0);
    chk("rst memdin", s_din, 32'h0);
    rst = 0;

    for (int i = 0; i < 19; i++) run(i, vt[i]);

    // Req held high across two loads; second accepted when Done pulses.
    @(negedge clk);
    sel = 0; req0 = 1; wr = 0; size = 2'b10; sign = 0; addr = 32'h08;
    @(negedge clk);
    chk("b2b busy1", {31'd0, s_busy}, 32'h1);
    chk("b2b done_early", {31'd0, s_done}, 32'h0);
    size = 2'b00; addr = 32'h09;
    @(negedge clk);
    chk("b2b done1", {31'd0, s_done}, 32'h1);
    chk("b2b rdata1", s_rdata, 32'hBEEF3380);
    chk("b2b idle", {31'd0, s_busy}, 32'h0);
    @(negedge clk);
    chk("b2b done_pulse", {31'd0, s_done}, 32'h0);
    chk("b2b busy2", {31'd0, s_busy}, 32'h1);
    @(negedge clk);
    req0 = 0;
    chk("b2b done2", {31'd0, s_done}, 32'h1);
    chk("b2b rdata2", s_rdata, 32'h00000033);
    @(negedge clk);
    chk("b2b no_third", {31'd0, s_busy}, 32'h0);

    // Reset during the WRITE cycle of a byte store.
    @(negedge clk);
    req0 = 1; wr = 1; size = 2'b00; addr = 32'h0A; wdata = 32'h55;
    @(negedge clk);
    req0 = 0;
    chk("abort merge busy", {31'd0, s_busy}, 32'h1);
    @(negedge clk);
    chk("abort write we", {31'd0, s_we}, 32'h1);
    rst = 1;
    #1 chk("abort we_gated", {31'd0, s_we}, 32'h0);
    @(negedge clk);
    rst = 0;
    chk("abort busy", {31'd0, s_busy}, 32'h0);
    chk("abort done", {31'd0, s_done}, 32'h0);
    chk("abort mem[2]", mem0[2], 32'hBEEF3380);
    chk("abort rdata", s_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the 32x32 word data memory; drives that memory's Addr/Din/We and consumes its Dout.
- Adds byte and halfword loads/stores (signed/unsigned), little-endian, on top of a word-only memory.
- Sub-word stores use a multi-cycle read-modify-write; every access reports completion through a Done pulse and a Busy stall.
- Misaligned accesses are flagged and never touch memory.

Parameters:
- MISALIGN_EN, 1: 1 = misaligned half/word access flagged and dropped; 0 = low address bits forced to alignment (Addr[0] cleared for half, Addr[1:0] cleared for word), no flag.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous reset, active-high.
- Req  in  1  access request; sampled only in IDLE.
- Wr  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- Sign  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- Addr  in  32  byte address.
- WData  in  32  store data; byte/half taken from low bits.
- RData  out  32  load result; valid while Done=1, held until next load completes.
- Done  out  1  one-cycle completion pulse (also on misalign).
- Misalign  out  1  valid with Done; 1 = access rejected.
- Busy  out  1  1 when state != IDLE.
- MemAddr  out  32  {addr_q[31:2], 2'b00} to memory.
- MemDin  out  32  write data to memory.
- MemWe  out  1  memory write enable.
- MemDout  in  32  asynchronous read data from memory.

Behaviour:
- Reset: state IDLE; RData, Done, Misalign, addr_q, wdata_q, merge_q all 0; MemWe=0.
- Reset mid-operation aborts the access with no memory write. MemWe = (state==WRITE) & ~Rst, so the reset edge never writes.
- States: IDLE, LOAD, MERGE, WRITE.
- IDLE, Req=1, aligned: latch Addr, WData, Size, Sign, Wr. Next state: load -> LOAD; word store -> WRITE (merge_q <= WData); byte/half store -> MERGE.
- IDLE, Req=1, misaligned (half with Addr[0]=1, word with Addr[1:0]!=0, or Size=11) and MISALIGN_EN=1: Done<=1, Misalign<=1, stay IDLE, no memory access. Size=11 is rejected even when MISALIGN_EN=0.
- LOAD: select the lane from MemDout (byte lane Addr[1:0], half lane Addr[1]), extend per Sign, register into RData. Done<=1, Misalign<=0, -> IDLE.
- MERGE: replace the target lane of MemDout with WData[7:0] or WData[15:0] into merge_q; other lanes preserved. -> WRITE.
- WRITE: MemDin=merge_q, MemWe=1. Done<=1, Misalign<=0, -> IDLE.
- Latency from the Req-sampling edge to the cycle with Done=1: load 2 cycles, word store 2, byte/half store 3, misalign 1.
- Done is a single-cycle pulse. A new Req may be sampled in the same cycle that Done is high, because the unit is back in IDLE.
- Req while Busy=1 is ignored; the CPU must stall on Busy and hold its request.
- RData is unchanged by stores and misaligned accesses.
- MemDin = merge_q in all states; MemWe=0 outside WRITE.
- MemAddr is driven from addr_q in all states.

Test Plan:
- Memory all zero. Word store 0x11223344 at 0x08 -> MemWe high exactly one cycle, Done 2 cycles after Req; word 2 = 0x11223344. Then signed byte load at 0x09 -> RData=0x00000033, Done 2 cycles after Req.
- Byte store 0xAB at 0x0A -> MERGE then WRITE, word 2 = 0x11AB3344, Done at cycle 3. Then signed byte load at 0x0A -> 0xFFFFFFAB; unsigned byte load at 0x0A -> 0x000000AB.
- Half store 0xBEEF at 0x0A -> word 2 = 0xBEEF3344. Then signed half load at 0x0A -> 0xFFFFBEEF; unsigned half load at 0x08 -> 0x00003344.
- MISALIGN_EN=1: half load at 0x03 -> Done=1 and Misalign=1 in the next cycle, MemWe never high, RData keeps its prior value. Word store at 0x06 -> same, memory unchanged. MISALIGN_EN=0: word store 0x5A5A5A5A at 0x06 -> word 1 written, Misalign=0.
- Rst asserted during the WRITE cycle of a byte store to 0x0A -> no write (word 2 unchanged), state IDLE, Done=0, Busy=0 next cycle.
- Back-to-back requests with Req held high: second Req ignored while Busy; it is accepted in the cycle Done pulses and completes with correct data.
